// File: rtl/hidden_layer_pkg.sv
// Shared types and helpers for the time-multiplexed hidden layer:
// FSM state encoding, width derivation and the activation stage.
// HIDDEN_RELU_EN selects ReLU activation; otherwise linear with signed saturation.
package hidden_layer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_BIAS,
    ST_ACT,
    ST_DONE
  } state_t;

  localparam int N_IN_DEF  = 4;
  localparam int IN_W_DEF  = 8;
  localparam int W_W_DEF   = 8;
  localparam int N_OUT_DEF = 3;
  localparam int OUT_W_DEF = 10;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int hl_clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < v) r = k + 1;
    end
    return r;
  endfunction

  // Accumulator wide enough for N_IN full-scale products plus the bias.
  function automatic int acc_width(input int n_in, input int in_w, input int w_w);
    return in_w + w_w + hl_clog2(n_in + 1);
  endfunction

  // One word per weight plus one bias word per neuron.
  function automatic int addr_width(input int n_out, input int n_in);
    return hl_clog2(n_out * (n_in + 1));
  endfunction

  localparam int ACC_W_DEF = acc_width(N_IN_DEF, IN_W_DEF, W_W_DEF);
  localparam int AW_DEF    = addr_width(N_OUT_DEF, N_IN_DEF);

  // Clamp a sign-extended accumulator into the output range; caller keeps the low out_w bits.
  function automatic logic signed [63:0] activate(input logic signed [63:0] a, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
`ifdef HIDDEN_RELU_EN
    hi = (64'sd1 <<< out_w) - 64'sd1;
    lo = 64'sd0;
`else
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
`endif
    if (a < lo) return lo;
    if (a > hi) return hi;
    return a;
  endfunction

endpackage

// File: rtl/hidden_layer_mac_neuron_mac.sv
// Single multiply-accumulate datapath shared by all neurons, followed by
// the activation/saturation stage. Operands are chosen by the top-level FSM.
// Activation mode follows HIDDEN_RELU_EN (see hidden_layer_pkg).
module neuron_mac
  import hidden_layer_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  x,
  input  logic signed [W_W-1:0]   w,
  output logic [OUT_W-1:0]        act
);

  logic signed [IN_W+W_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_reg;
  logic signed [63:0]         acc_wide;

  assign prod     = x * w;
  assign prod_ext = {{(ACC_W-IN_W-W_W){prod[IN_W+W_W-1]}}, prod};
  assign acc_wide = {{(64-ACC_W){acc_reg[ACC_W-1]}}, acc_reg};
  assign act      = OUT_W'(activate(acc_wide, OUT_W));

  // Accumulator: clear has priority so a new neuron never sees stale sums.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + prod_ext;
    end
  end

endmodule

// File: rtl/hidden_layer_mac.sv
// Hidden layer of N_OUT neurons with N_IN signed inputs each, computed on one
// shared MAC. Holds the weight/bias register file, counters and the control FSM.
// HIDDEN_RELU_EN selects ReLU activation; otherwise linear with signed saturation.
module hidden_layer_mac
  import hidden_layer_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int IN_W  = IN_W_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int OUT_W = OUT_W_DEF,
  localparam int ACC_W = acc_width(N_IN, IN_W, W_W),
  localparam int AW    = addr_width(N_OUT, N_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN*IN_W-1:0]    input_vec,
  input  logic                    start,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [W_W-1:0]          wr_data,
  output logic [N_OUT*OUT_W-1:0]  output_val,
  output logic                    busy,
  output logic                    done,
  output logic                    wr_err
);

  localparam int N_WORDS = N_OUT * (N_IN + 1);
  localparam int IW      = (hl_clog2(N_IN) > 0) ? hl_clog2(N_IN) : 1;
  localparam int JW      = (hl_clog2(N_OUT) > 0) ? hl_clog2(N_OUT) : 1;

  state_t                 state_reg;
  logic [IW-1:0]          i_reg;
  logic [JW-1:0]          j_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   wr_err_reg;
  logic signed [IN_W-1:0] x_mem [N_IN];
  logic signed [W_W-1:0]  w_mem [N_WORDS];

  logic                   mac_en;
  logic                   mac_clr;
  logic                   wr_ok;
  logic [AW-1:0]          rd_addr;
  logic signed [IN_W-1:0] op_x;
  logic signed [W_W-1:0]  op_w;
  logic [OUT_W-1:0]       act;
  logic                   last_neuron;

  assign last_neuron = (j_reg == JW'(N_OUT - 1));
  assign mac_en  = (state_reg == ST_MAC) || (state_reg == ST_BIAS);
  assign mac_clr = ((state_reg == ST_IDLE) && start) || (state_reg == ST_ACT);
  assign wr_ok   = (state_reg == ST_IDLE) && ({1'b0, wr_addr} < (AW+1)'(N_WORDS));
  // The bias word of neuron j follows its N_IN weights; bias enters the MAC as 1*bias.
  assign rd_addr = AW'(j_reg) * AW'(N_IN + 1)
                 + ((state_reg == ST_BIAS) ? AW'(N_IN) : AW'(i_reg));
  assign op_x    = (state_reg == ST_BIAS) ? IN_W'(1) : x_mem[i_reg];
  assign op_w    = w_mem[rd_addr];

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign wr_err = wr_err_reg;

  neuron_mac #(
    .IN_W  (IN_W),
    .W_W   (W_W),
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .x   (op_x),
    .w   (op_w),
    .act (act)
  );

  // Control FSM: sequences products, bias and activation for each neuron in turn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      for (int k = 0; k < N_IN; k++) x_mem[k] <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            for (int k = 0; k < N_IN; k++) x_mem[k] <= input_vec[k*IN_W +: IN_W];
            i_reg     <= '0;
            j_reg     <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (i_reg == IW'(N_IN - 1)) state_reg <= ST_BIAS;
          else                        i_reg     <= i_reg + 1'b1;
        end
        ST_BIAS: state_reg <= ST_ACT;
        ST_ACT: begin
          if (last_neuron) begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            i_reg     <= '0;
            j_reg     <= j_reg + 1'b1;
            state_reg <= ST_MAC;
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Weight/bias register file: writes only land while idle and in range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_err_reg <= 1'b0;
      for (int k = 0; k < N_WORDS; k++) w_mem[k] <= '0;
    end else begin
      wr_err_reg <= wr_en && !wr_ok;
      if (wr_en && wr_ok) w_mem[wr_addr] <= wr_data;
    end
  end

  // Per-neuron shadow slots; the visible result bank updates all at once so
  // output_val never shows a partially computed layer and is valid with done.
  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_slot
      logic [OUT_W-1:0] shadow_reg;
      logic [OUT_W-1:0] out_reg;

      // Capture the activated sum of this neuron.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                           shadow_reg <= '0;
        else if ((state_reg == ST_ACT) && (j_reg == JW'(gi))) shadow_reg <= act;
      end

      // Publish the whole layer when the last neuron finishes.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   out_reg <= '0;
        else if ((state_reg == ST_ACT) && last_neuron) out_reg <= (gi == N_OUT - 1) ? act : shadow_reg;
      end

      assign output_val[gi*OUT_W +: OUT_W] = out_reg;
    end
  endgenerate

endmodule
